// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module : ctrl_pipe
// Parametrised control-word pipeline with per-stage valid, stall, flush,
// bubble insertion, occupancy count and saturating retire counter.
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_pipe #(
    parameter int             W      = 11,
    parameter int             STAGES = 3,
    parameter logic [W-1:0]   BUBBLE = '0,
    parameter int             CW     = 32,
    localparam int            OW     = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          ctrl_in,
    input  logic                  valid_in,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   ctrl_q,
    output logic [STAGES-1:0]     valid_q,
    output logic [OW-1:0]         occupancy,
    output logic [CW-1:0]         retire_cnt
);

    logic [W-1:0]      word  [STAGES];
    logic              vld   [STAGES];
    logic [STAGES-1:0] hold;

    // A stage is frozen whenever it or any stage downstream of it stalls.
    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_hold
            assign hold[i] = |stall[STAGES-1:i];
        end
    endgenerate

    assign in_ready = ~hold[0];

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            if (i == 0) begin : g_head
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        word[i] <= BUBBLE;
                        vld[i]  <= 1'b0;
                    end else if (flush[i]) begin
                        word[i] <= BUBBLE;
                        vld[i]  <= 1'b0;
                    end else if (!hold[i]) begin
                        word[i] <= ctrl_in;
                        vld[i]  <= valid_in;
                    end
                end
            end else begin : g_body
                // Upstream frozen while this stage drains: insert a bubble.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        word[i] <= BUBBLE;
                        vld[i]  <= 1'b0;
                    end else if (flush[i]) begin
                        word[i] <= BUBBLE;
                        vld[i]  <= 1'b0;
                    end else if (!hold[i]) begin
                        if (stall[i-1]) begin
                            word[i] <= BUBBLE;
                            vld[i]  <= 1'b0;
                        end else begin
                            word[i] <= word[i-1];
                            vld[i]  <= vld[i-1];
                        end
                    end
                end
            end

            assign ctrl_q[i*W +: W] = word[i];
            assign valid_q[i]       = vld[i];
        end
    endgenerate

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OW'(vld[i]);
        end
    end

    // A word leaving the last stage counts even if that stage is flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (vld[STAGES-1] && !stall[STAGES-1] && (retire_cnt != {CW{1'b1}})) begin
            retire_cnt <= retire_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire
